// File: rtl/afifo_rd_drain_if.sv
// afifo_rd_drain_if: FIFO read port plus registered valid/ready output stream of the drain block.
interface afifo_rd_drain_if #(
    parameter int WIDTH = 8
);
    logic             rempty;
    logic [WIDTH-1:0] rdata;
    logic             rinc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        input  rempty,
        input  rdata,
        output rinc,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport slave (
        output rempty,
        output rdata,
        input  rinc,
        input  out_valid,
        output out_ready,
        input  out_data
    );
endinterface

// File: rtl/afifo_rd_drain.sv
// afifo_rd_drain: drains a FWFT FIFO read port into a registered stream and checks each word
// against a constant or incrementing pattern, keeping sticky error status and counters.
module afifo_rd_drain #(
    parameter int               WIDTH    = 8,
    parameter int               LEN_W    = 16,
    parameter int               ERR_W    = 8,
    parameter logic [WIDTH-1:0] EXP_INIT = WIDTH'(1)
) (
    input  logic             i_rclk,
    input  logic             i_rrst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [LEN_W-1:0] i_rd_len,
    input  logic             i_mode,
    afifo_rd_drain_if.master bus,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_rd_cnt,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [WIDTH-1:0] o_err_data
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_rd_cnt;
    logic [LEN_W-1:0] w_cnt_inc;
    logic             r_mode;
    logic             r_err;
    logic             r_out_valid;
    logic             w_pop;
    logic             w_miss;
    logic             w_last;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_err_data;
    logic [ERR_W-1:0] r_err_cnt;

    assign w_cnt_inc = r_rd_cnt + LEN_W'(1);
    assign w_pop     = (r_state == RUN) && !bus.rempty && !i_stop
                       && (r_len == '0 || r_rd_cnt != r_len)
                       && (!r_out_valid || bus.out_ready);
    assign w_miss    = w_pop && (bus.rdata != r_exp);
    // Leave RUN on the same edge that pops the final word.
    assign w_last    = (r_len != '0) && (r_rd_cnt == r_len || (w_pop && w_cnt_inc == r_len));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? RUN : IDLE;
            RUN:     w_next = (i_stop || w_last) ? FLUSH : RUN;
            FLUSH:   w_next = (!r_out_valid || bus.out_ready) ? DONE : FLUSH;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_rclk) begin
        if (i_rrst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_mode      <= 1'b0;
            r_exp       <= EXP_INIT;
            r_rd_cnt    <= '0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_err_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_start) begin
                r_len      <= i_rd_len;
                r_mode     <= i_mode;
                r_exp      <= EXP_INIT;
                r_rd_cnt   <= '0;
                r_err      <= 1'b0;
                r_err_cnt  <= '0;
                r_err_data <= '0;
            end
            if (w_pop) begin
                r_out_data <= bus.rdata;
                r_rd_cnt   <= w_cnt_inc;
                r_exp      <= r_mode ? bus.rdata + WIDTH'(1) : r_exp;
            end
            if (w_miss) begin
                r_err      <= 1'b1;
                r_err_cnt  <= (&r_err_cnt) ? r_err_cnt : r_err_cnt + ERR_W'(1);
                r_err_data <= r_err ? r_err_data : bus.rdata;
            end
            r_out_valid <= w_pop || (r_out_valid && !bus.out_ready);
        end
    end

    assign bus.rinc      = w_pop;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign o_busy        = (r_state == RUN) || (r_state == FLUSH);
    assign o_done        = (r_state == DONE);
    assign o_rd_cnt      = r_rd_cnt;
    assign o_err         = r_err;
    assign o_err_cnt     = r_err_cnt;
    assign o_err_data    = r_err_data;
endmodule
